// File: rtl/snac_pkg.sv
// Shared types and helpers for the SNAC serial controller reader.
package snac_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_e;

  // Location of one serial bit inside the per-player button words.
  typedef struct packed {
    int player;
    int bit_pos;
  } bit_loc_t;

  // Number of serial bits clocked out of the whole controller chain per frame.
  function automatic int total_bits(input int players, input int bits);
    return players * bits;
  endfunction

  // Map serial bit k to {player, bit}. Player-major sends all bits of player 0
  // first; interleaved sends bit 0 of every player, then bit 1, and so on.
  function automatic bit_loc_t map_bit(input int k, input logic interleave,
                                       input int players, input int bits);
    bit_loc_t loc;
    if (interleave) begin
      loc.player  = k % players;
      loc.bit_pos = k / players;
    end else begin
      loc.player  = k / bits;
      loc.bit_pos = k % bits;
    end
    return loc;
  endfunction

endpackage

// File: rtl/snac_sync2.sv
// Two-flop synchronizer for the asynchronous controller data line.
module snac_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/snac_serial_joy_reader.sv
// Polls a chain of SNAC serial controllers: pulses LATCH, clocks out
// PLAYERS*BITS bits, and publishes per-player button words and presence flags.
module snac_serial_joy_reader
  import snac_pkg::*;
#(
  parameter int PLAYERS         = 2,
  parameter int BITS            = 16,
  parameter int DIV             = 64,
  parameter int GAP             = 4096,
  parameter bit DATA_ACTIVE_LOW = 1'b1,
  parameter bit ABSENT_LEVEL    = 1'b1
) (
  input  logic                    clk_sys,
  input  logic                    reset_l_main,
  input  logic                    enable,
  input  logic                    interleave,
  input  logic                    joy_data,
  output logic                    joy_latch,
  output logic                    joy_clk,
  output logic [PLAYERS*BITS-1:0] joy_flat,
  output logic [PLAYERS-1:0]      joy_present,
  output logic                    joy_valid
);

  localparam int TOTAL = total_bits(PLAYERS, BITS);
  localparam int HC_W  = (DIV   > 1) ? $clog2(DIV)   : 1;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int GC_W  = (GAP   > 1) ? $clog2(GAP)   : 1;
  localparam int PW    = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam int BW    = (BITS    > 1) ? $clog2(BITS)    : 1;

  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(GAP - 1);

  // Synchronized serial data.
  logic data_s;

  snac_sync2 u_sync (
    .clk   (clk_sys),
    .rst_n (reset_l_main),
    .d     (joy_data),
    .q     (data_s)
  );

  // Sequencer state and datapath registers.
  state_e                    state_q,   state_d;
  logic [HC_W-1:0]           hc_q,      hc_d;
  logic [IDX_W-1:0]          idx_q,     idx_d;
  logic [GC_W-1:0]           gc_q,      gc_d;
  logic                      il_q,      il_d;
  logic [TOTAL-1:0]          raw_q,     raw_d;
  logic                      latch_q,   latch_d;
  logic                      clk_q,     clk_d;
  logic [PLAYERS*BITS-1:0]   flat_q,    flat_d;
  logic [PLAYERS-1:0]        present_q, present_d;
  logic                      valid_q,   valid_d;

  // Decoded frame contents.
  logic [BITS-1:0]         word_pm  [PLAYERS];
  logic [BITS-1:0]         word_il  [PLAYERS];
  logic [BITS-1:0]         word_sel [PLAYERS];
  logic [PLAYERS*BITS-1:0] flat_calc;
  logic [PLAYERS-1:0]      present_calc;
  bit_loc_t                loc_pm;
  bit_loc_t                loc_il;

  // Scatter the raw serial bits into per-player words for both bit orders.
  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      word_pm[p] = '0;
      word_il[p] = '0;
    end
    loc_pm = '0;
    loc_il = '0;
    for (int k = 0; k < TOTAL; k++) begin
      loc_pm = map_bit(k, 1'b0, PLAYERS, BITS);
      loc_il = map_bit(k, 1'b1, PLAYERS, BITS);
      word_pm[PW'(loc_pm.player)][BW'(loc_pm.bit_pos)] = raw_q[k];
      word_il[PW'(loc_il.player)][BW'(loc_il.bit_pos)] = raw_q[k];
    end
  end

  // Pick the order captured at frame start, detect absent players, normalise polarity.
  always_comb begin
    flat_calc    = '0;
    present_calc = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      word_sel[p]     = il_q ? word_il[p] : word_pm[p];
      present_calc[p] = (word_sel[p] != {BITS{ABSENT_LEVEL}});
      if (present_calc[p]) begin
        flat_calc[p*BITS +: BITS] = word_sel[p] ^ {BITS{DATA_ACTIVE_LOW}};
      end
    end
  end

  // Next-state logic for the frame sequencer; enable low aborts any frame.
  always_comb begin
    // NOTE: every _d signal takes its held value first, so no branch can infer a latch.
    state_d   = state_q;
    hc_d      = hc_q;
    idx_d     = idx_q;
    gc_d      = gc_q;
    il_d      = il_q;
    raw_d     = raw_q;
    flat_d    = flat_q;
    present_d = present_q;
    valid_d   = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      hc_d    = '0;
      idx_d   = '0;
      gc_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gc_q == GC_LAST) begin
            gc_d    = '0;
            hc_d    = '0;
            il_d    = interleave;
            state_d = LATCH;
          end else begin
            gc_d = gc_q + 1'b1;
          end
        end
        LATCH: begin
          if (hc_q == HC_LAST) begin
            hc_d    = '0;
            idx_d   = '0;
            state_d = SHIFT_LO;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        SHIFT_LO: begin
          if (hc_q == HC_LAST) begin
            hc_d         = '0;
            raw_d[idx_q] = data_s;
            state_d      = SHIFT_HI;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (hc_q == HC_LAST) begin
            hc_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = SHIFT_LO;
            end
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        DONE: begin
          flat_d    = flat_calc;
          present_d = present_calc;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Wire outputs follow the next state so they come straight from flops.
  always_comb begin
    latch_d = (state_d == LATCH);
    clk_d   = (state_d == SHIFT_HI);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_l_main) begin
    if (!reset_l_main) begin
      state_q   <= IDLE;
      hc_q      <= '0;
      idx_q     <= '0;
      gc_q      <= '0;
      il_q      <= 1'b0;
      raw_q     <= '0;
      latch_q   <= 1'b0;
      clk_q     <= 1'b0;
      flat_q    <= '0;
      present_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so all flops update together.
      state_q   <= state_d;
      hc_q      <= hc_d;
      idx_q     <= idx_d;
      gc_q      <= gc_d;
      il_q      <= il_d;
      raw_q     <= raw_d;
      latch_q   <= latch_d;
      clk_q     <= clk_d;
      flat_q    <= flat_d;
      present_q <= present_d;
      valid_q   <= valid_d;
    end
  end

  assign joy_latch   = latch_q;
  assign joy_clk     = clk_q;
  assign joy_flat    = flat_q;
  assign joy_present = present_q;
  assign joy_valid   = valid_q;

endmodule

// File: tb/tb_snac_serial_joy_reader.sv
// Self-checking bench for snac_serial_joy_reader (2 players x 4 bits).
module tb_snac_serial_joy_reader;

  localparam int P      = 2;
  localparam int B      = 4;
  localparam int DIV    = 4;
  localparam int GAP    = 8;
  localparam int TOT    = P * B;
  localparam int PERIOD = GAP + DIV + 2 * DIV * TOT + 1;

  logic           clk_sys      = 1'b0;
  logic           reset_l_main = 1'b1;
  logic           enable       = 1'b0;
  logic           interleave   = 1'b0;
  logic           joy_data     = 1'b1;
  logic           joy_latch;
  logic           joy_clk;
  logic [TOT-1:0] joy_flat;
  logic [P-1:0]   joy_present;
  logic           joy_valid;

  always #5 clk_sys = ~clk_sys;

  snac_serial_joy_reader #(
    .PLAYERS         (P),
    .BITS            (B),
    .DIV             (DIV),
    .GAP             (GAP),
    .DATA_ACTIVE_LOW (1'b1),
    .ABSENT_LEVEL    (1'b1)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_l_main (reset_l_main),
    .enable       (enable),
    .interleave   (interleave),
    .joy_data     (joy_data),
    .joy_latch    (joy_latch),
    .joy_clk      (joy_clk),
    .joy_flat     (joy_flat),
    .joy_present  (joy_present),
    .joy_valid    (joy_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wire level the controllers return for serial bit k (stream[k]).
  logic [TOT-1:0] stream = '0;

  // Controller chain: latch loads bit 0, each falling clock presents the next bit.
  initial begin
    int  ptr;
    logic prev_clk;
    ptr      = TOT;
    prev_clk = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (joy_latch) ptr = 0;
      else if (prev_clk && !joy_clk) ptr = ptr + 1;
      prev_clk = joy_clk;
      joy_data = (ptr < TOT) ? stream[ptr] : 1'b1;
    end
  end

  // Expected frame result from the mapping, presence and polarity rules.
  function automatic logic [TOT+P-1:0] frame_result(input logic [TOT-1:0] s, input logic il);
    logic [B-1:0]   w [P];
    logic [TOT-1:0] f;
    logic [P-1:0]   pr;
    int p;
    int b;
    for (int i = 0; i < P; i++) w[i] = '0;
    for (int k = 0; k < TOT; k++) begin
      if (il) begin p = k % P; b = k / P; end
      else    begin p = k / B; b = k % B; end
      w[p][b] = s[k];
    end
    f  = '0;
    pr = '0;
    for (int i = 0; i < P; i++) begin
      pr[i] = (w[i] != {B{1'b1}});
      if (pr[i]) f[i*B +: B] = ~w[i];
    end
    return {pr, f};
  endfunction

  // Model: t = clock edges since polling (re)started; the frame is a fixed timeline.
  int             t           = 0;
  logic           il_m        = 1'b0;
  logic [TOT-1:0] exp_flat    = '0;
  logic [P-1:0]   exp_present = '0;

  always @(posedge clk_sys or negedge reset_l_main) begin
    if (!reset_l_main) begin
      t           <= 0;
      il_m        <= 1'b0;
      exp_flat    <= '0;
      exp_present <= '0;
    end else if (!enable) begin
      t <= 0;
    end else begin
      t <= t + 1;
      if ((t + 1) % PERIOD == GAP) il_m <= interleave;
      if ((t + 1) % PERIOD == 0) {exp_present, exp_flat} <= frame_result(stream, il_m);
    end
  end

  // Compare every cycle, away from the active edge.
  bit checking = 1'b0;

  always @(negedge clk_sys) begin
    int   ph;
    int   j;
    logic e_latch;
    logic e_clk;
    logic e_valid;
    if (checking) begin
      ph      = t % PERIOD;
      j       = ph - GAP - DIV;
      e_latch = (ph >= GAP) && (ph < GAP + DIV);
      e_clk   = (ph >= GAP + DIV) && (ph < PERIOD - 1) && ((j / DIV) % 2 == 1);
      e_valid = (t > 0) && (ph == 0);
      check("cyc_latch",   64'(joy_latch),   64'(e_latch));
      check("cyc_clk",     64'(joy_clk),     64'(e_clk));
      check("cyc_valid",   64'(joy_valid),   64'(e_valid));
      check("cyc_flat",    64'(joy_flat),    64'(exp_flat));
      check("cyc_present", 64'(joy_present), 64'(exp_present));
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!joy_valid && n < 300);
  endtask

  task automatic stop_and_load(input logic [TOT-1:0] s, input logic il);
    @(negedge clk_sys);
    enable = 1'b0;
    repeat (3) @(negedge clk_sys);
    stream     = s;
    interleave = il;
    @(negedge clk_sys);
    enable = 1'b1;
  endtask

  initial begin
    int n;
    int latch_cnt;
    int clk_hi;
    int clk_rise;
    int valids;
    logic prev;

    #1 reset_l_main = 1'b0;
    repeat (3) @(negedge clk_sys);
    checking = 1'b1;
    check("rst_flat",    64'(joy_flat),    64'h0);
    check("rst_present", 64'(joy_present), 64'h0);
    check("rst_valid",   64'(joy_valid),   64'h0);
    check("rst_latch",   64'(joy_latch),   64'h0);
    check("rst_clk",     64'(joy_clk),     64'h0);

    // All buttons pressed, period and waveform.
    stream       = '0;
    reset_l_main = 1'b1;
    enable       = 1'b1;
    wait_valid(n);
    check("first_valid_cycles", 64'(n), 64'd77);
    latch_cnt = 0; clk_hi = 0; clk_rise = 0; prev = 1'b0; n = 0;
    do begin
      @(negedge clk_sys);
      n++;
      latch_cnt += int'(joy_latch);
      clk_hi    += int'(joy_clk);
      if (joy_clk && !prev) clk_rise++;
      prev = joy_clk;
    end while (!joy_valid && n < 300);
    check("period",        64'(n),           64'd77);
    check("latch_cycles",  64'(latch_cnt),   64'd4);
    check("clk_pulses",    64'(clk_rise),    64'd8);
    check("clk_hi_cycles", 64'(clk_hi),      64'd32);
    check("all_flat",      64'(joy_flat),    64'hFF);
    check("all_present",   64'(joy_present), 64'h3);

    // Player-major: raw 0,1,1,1 / 1,0,1,1.
    stop_and_load(8'hDE, 1'b0);
    wait_valid(n);
    check("pm_cycles",  64'(n),           64'd77);
    check("pm_flat",    64'(joy_flat),    64'h21);
    check("pm_present", 64'(joy_present), 64'h3);

    // Interleaved, with a mid-frame interleave change that must not matter.
    stop_and_load(8'hDE, 1'b1);
    repeat (40) @(negedge clk_sys);
    interleave = 1'b0;
    wait_valid(n);
    check("il_cycles", 64'(n + 40),    64'd77);
    check("il_flat",   64'(joy_flat),  64'h41);
    wait_valid(n);
    check("il_next_flat", 64'(joy_flat), 64'h21);

    // Absent player 1, player 0 raw 1,1,1,0.
    stop_and_load(8'hF7, 1'b0);
    wait_valid(n);
    check("abs_flat",    64'(joy_flat),    64'h08);
    check("abs_present", 64'(joy_present), 64'h1);

    // Abort during SHIFT_HI.
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!joy_clk && n < 300);
    check("abort_clk_seen", 64'(joy_clk), 64'h1);
    enable = 1'b0;
    @(negedge clk_sys);
    check("abort_latch", 64'(joy_latch), 64'h0);
    check("abort_clk",   64'(joy_clk),   64'h0);
    check("abort_flat",  64'(joy_flat),  64'h08);
    valids = 0;
    repeat (100) begin
      @(negedge clk_sys);
      valids += int'(joy_valid);
    end
    check("abort_no_valid", 64'(valids), 64'd0);
    enable = 1'b1;
    wait_valid(n);
    check("reenable_cycles", 64'(n),        64'd77);
    check("reenable_flat",   64'(joy_flat), 64'h08);

    // Asynchronous reset mid-frame.
    stop_and_load(8'hDE, 1'b0);
    repeat (17) @(negedge clk_sys);
    check("pre_reset_clk", 64'(joy_clk), 64'h1);
    #2 reset_l_main = 1'b0;
    #1;
    check("mid_rst_flat",    64'(joy_flat),    64'h0);
    check("mid_rst_present", 64'(joy_present), 64'h0);
    check("mid_rst_valid",   64'(joy_valid),   64'h0);
    check("mid_rst_latch",   64'(joy_latch),   64'h0);
    check("mid_rst_clk",     64'(joy_clk),     64'h0);
    @(negedge clk_sys);
    reset_l_main = 1'b1;
    wait_valid(n);
    check("post_rst_cycles", 64'(n),           64'd77);
    check("post_rst_flat",   64'(joy_flat),    64'h21);
    check("post_rst_present", 64'(joy_present), 64'h3);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/snac_serial_joy_reader.md
Name: snac_serial_joy_reader

Overview:
- Parametrised successor to the fixed two-player DB15 SNAC reader that drives the Analogizer cart-port lines.
- Generates the LATCH/CLK serial protocol on the SNAC outputs and shifts in PLAYERS×BITS bits from the DATA line.
- Supports player-major or interleaved bit order, and active-high or active-low data.
- Publishes per-player button words, a per-player presence flag and a one-cycle frame-valid strobe to the emu core inputs (snac_p1/snac_p2...).

Parameters:
- PLAYERS, 2, number of controllers in the chain, 1..4.
- BITS, 16, bits per player, 4..32.
- DIV, 64, clk_sys cycles per half-period of joy_clk and per latch pulse, >=4.
- GAP, 4096, idle clk_sys cycles between frames, >=1.
- DATA_ACTIVE_LOW, 1, 1 = a pressed button reads 0 on the wire; outputs are inverted so 1 = pressed.
- ABSENT_LEVEL, 1, raw wire level a disconnected player returns on every bit.

Ports:
- clk_sys  in  1  system clock.
- reset_l_main  in  1  asynchronous active-low reset.
- enable  in  1  1 = poll continuously.
- interleave  in  1  0 = player-major order; 1 = player-interleaved order. Sampled at frame start.
- joy_data  in  1  serial data from cart pin; asynchronous.
- joy_latch  out  1  SNAC latch (OUT2).
- joy_clk  out  1  SNAC clock (OUT1).
- joy_flat  out  PLAYERS*BITS  player p occupies [p*BITS +: BITS]; 1 = pressed.
- joy_present  out  PLAYERS  per-player connection flag.
- joy_valid  out  1  one-cycle pulse when joy_flat/joy_present update.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, gap counter 0, shift register cleared.
- Reset is asynchronous and active-low and may land mid-frame; release restarts with a full GAP.
- joy_data passes through a 2-flop synchronizer (data_s) before any use.
- Counters:
  - hc counts half-period cycles 0..DIV-1.
  - idx counts 0..PLAYERS*BITS-1.
  - gc counts 0..GAP-1.
  - Widths are $clog2 of each range, minimum 1.
- FSM states:
  - IDLE: latch=0, clk=0. gc increments while enable=1. At gc==GAP-1: gc←0, capture interleave into il_q, go to LATCH.
  - LATCH: latch=1 for DIV cycles, then go to SHIFT_LO with idx=0.
  - SHIFT_LO: clk=0. At hc==DIV-1: raw[idx]←data_s, go to SHIFT_HI.
  - SHIFT_HI: clk=1. At hc==DIV-1: if idx==PLAYERS*BITS-1 go to DONE, else idx++ and go to SHIFT_LO.
  - DONE: one cycle, registers outputs, joy_valid=1, then go to IDLE.
- Bit mapping for serial bit k:
  - il_q=0: player k/BITS, bit k%BITS.
  - il_q=1: player k%PLAYERS, bit k/PLAYERS.
- Presence and output words:
  - joy_present[p] = 0 iff all BITS raw bits of player p equal ABSENT_LEVEL.
  - Word for player p = raw bits XOR {BITS{DATA_ACTIVE_LOW}}, forced to 0 when the player is not present.
- Frame period = GAP + DIV + 2·DIV·PLAYERS·BITS + 1 cycles.
- Outputs hold their last values between DONE pulses.
- enable=0:
  - In IDLE: gc is held at 0.
  - In any other state: abort on the next cycle to IDLE with latch=0, clk=0, idx=0, hc=0. No joy_valid; outputs keep their previous values.
- interleave changes mid-frame have no effect until the next frame.
- Outputs joy_latch and joy_clk are registered (glitch-free); no combinational path from joy_data to any output.

Decomposition:
- Package snac_pkg holds:
  - state enum {IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE};
  - localparam helper for total bits;
  - bit-map function (k, interleave) → {player, bit}.
- One sub-module: snac_sync2 (2-flop synchronizer, async active-low reset to 0).

Test Plan:
- Common bench configuration: PLAYERS=2, BITS=4, DIV=4, GAP=8, DATA_ACTIVE_LOW=1, ABSENT_LEVEL=1.
- Period/waveform:
  - Stimulus: enable=1, joy_data=0 constant.
  - Required: joy_valid pulses every 77 cycles; latch high 4 cycles; 8 clk high pulses of 4 cycles each; joy_flat=8'hFF; joy_present=2'b11.
- Player-major mapping:
  - Stimulus: interleave=0; bench model drives serial raw 0,1,1,1 then 1,0,1,1 (k=0..7).
  - Required: p0 word 4'b0001, p1 word 4'b0010.
- Interleaved mapping:
  - Stimulus: same serial stream with interleave=1.
  - Required: p0 bits from k=0,2,4,6 (raw 0,1,1,1) → 4'b0001; p1 from k=1,3,5,7 (raw 1,1,0,1) → 4'b0100.
- Absent player:
  - Stimulus: p1's 4 bits all 1, p0 raw 1,1,1,0.
  - Required: joy_present=2'b01; p1 word 0; p0 word 4'b1000.
- Abort/reset:
  - Stimulus: drop enable during SHIFT_HI.
  - Required: latch and clk both low next cycle; no joy_valid; joy_flat unchanged. Re-enable → first joy_valid occurs 77 cycles later.
  - Stimulus: assert reset_l_main=0 mid-frame.
  - Required: all outputs 0 asynchronously.
